// File: rtl/snn_pkg.sv
// Shared definitions for the spike encoder slice: LFSR polynomial, encoder
// state encoding and the per-pixel seed derivation.
package snn_pkg;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Pixel idx uses base+idx (mod 256); zero would lock the LFSR, so it maps to 1.
  function automatic logic [7:0] pixel_seed(input logic [7:0] base, input int unsigned idx);
    logic [7:0] s;
    s = base + idx[7:0];
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/spike_lfsr8.sv
// 8-bit right-shifting Galois LFSR (maximal length); reload has priority over advance.
module spike_lfsr8
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (advance) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes an S-pixel patch into T_STEPS binary spike vectors, one per
// valid/ready transfer; pixel i drives pixels_out[(S-1)-i].
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int unsigned S       = 25,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned T_STEPS = 16,
  parameter logic [7:0]  SEED    = 8'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [S*WIDTH-1:0] pixel_in,
  output logic [S-1:0]       pixels_out,
  output logic               spike_valid,
  input  logic               spike_ready,
  output logic [7:0]         timestep,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0] LAST_TS = 8'(T_STEPS - 1);

  enc_state_e       state_q;
  logic [WIDTH-1:0] intensity_q [S];
  logic [7:0]       timestep_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             advance;
  logic [7:0]       rnd [S];
  logic [S-1:0]     spike_raw;

  assign load    = (state_q == IDLE) && start;
  assign advance = valid_q && spike_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timestep_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      // NOTE: the intensity array is reset explicitly so nothing stale can fire after reset.
      for (int i = 0; i < S; i++) begin
        intensity_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= EMIT;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            timestep_q <= '0;
            for (int i = 0; i < S; i++) begin
              intensity_q[i] <= pixel_in[S*WIDTH-1-WIDTH*i -: WIDTH];
            end
          end
        end
        EMIT: begin
          if (spike_ready) begin
            // Clear rather than increment on the last step so T_STEPS=256 cannot wrap.
            if (timestep_q == LAST_TS) begin
              state_q    <= DONE;
              valid_q    <= 1'b0;
              done_q     <= 1'b1;
              timestep_q <= '0;
            end else begin
              timestep_q <= timestep_q + 8'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < S; g++) begin : g_pixel
    spike_lfsr8 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .seed    (pixel_seed(SEED, g)),
      .advance (advance),
      .state   (rnd[g])
    );

    assign spike_raw[S-1-g] = (intensity_q[g] >= rnd[g]);
  end

  // Comparator inputs only move on a transfer or load, so the vector is stable under stall.
  assign pixels_out  = valid_q ? spike_raw : '0;
  assign spike_valid = valid_q;
  assign timestep    = timestep_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
